// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the pipeline's memory-access stage. Accepts one
// load or store at a time, inserts WAIT_CYCLES wait states, then commits a
// byte-lane-merged store into an internal word array or returns a sign- or
// zero-extended load result. Malformed, misaligned and out-of-range requests
// complete with mem_error and have no side effects.
//
// Parameters
//   XLEN        : data/address width (32 or 64); array word width
//   DEPTH_WORDS : number of XLEN-bit words in the array (power of two)
//   BASE_ADDR   : byte address of word 0, aligned to the array size
//   WAIT_CYCLES : extra cycles between acceptance and response (0..15)
//
// Ports
//   clk           in   clock, rising edge
//   resetn        in   asynchronous active-low reset
//   mem_addr      in   byte address
//   mem_wdata     in   store data, right-justified
//   mem_read_req  in   load request, level-held
//   mem_write_req in   store request, level-held
//   mem_size      in   0 = byte, 1 = half, 2 = word, 3 = double
//   mem_signed    in   1 = sign-extend loads, 0 = zero-extend
//   mem_rdata     out  load result, valid while mem_ready is high
//   mem_ready     out  one-cycle completion pulse
//   mem_error     out  request faulted, qualified by mem_ready
//   busy          out  responder is not idle
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int          XLEN        = 64,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'd0,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic            mem_read_req,
    input  logic            mem_write_req,
    input  logic [2:0]      mem_size,
    input  logic            mem_signed,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_ready,
    output logic            mem_error,
    output logic            busy
);

    localparam int NBYTES = XLEN / 8;
    localparam int LG     = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);

    localparam logic [XLEN-1:0] BASE      = BASE_ADDR[XLEN-1:0];
    // Array span in bytes, one bit wider than an address so it never wraps.
    localparam logic [XLEN:0]   SPAN      = (XLEN + 1)'(DEPTH_WORDS) << LG;
    localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Everything needed to finish a request, captured at acceptance.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [LG-1:0]    lane;
        logic [XLEN-1:0]  wdata;
        logic [2:0]       size;
        logic             sign;
        logic             write;
        logic             err;
    } req_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    req_t            req_q;
    logic [XLEN-1:0] rdata_q;
    logic            ready_q;
    logic            error_q;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    // -----------------------------------------------------------------------
    // Request decode and error check on the live inputs
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] offset;
    logic            req_valid;
    req_t            req_in;

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        req_in       = '0;
        offset       = mem_addr - BASE;
        req_valid    = mem_read_req | mem_write_req;
        req_in.idx   = offset[LG +: IDX_W];
        req_in.lane  = offset[LG-1:0];
        req_in.wdata = mem_wdata;
        req_in.size  = mem_size;
        req_in.sign  = mem_signed;
        req_in.write = mem_write_req;
        req_in.err   = (mem_size > 3'(LG))
                     | (|(mem_addr & ~({XLEN{1'b1}} << mem_size)))
                     | (mem_addr < BASE)
                     | ({1'b0, offset} >= SPAN)
                     | (mem_read_req & mem_write_req);
    end

    // -----------------------------------------------------------------------
    // Response datapath
    //
    // With WAIT_CYCLES == 0 the acceptance edge is also the edge entering
    // RESP, so the live request is used in IDLE and the latched one otherwise.
    // -----------------------------------------------------------------------
    req_t              cur;
    logic              enter_resp;
    logic              mem_we;
    logic [LG+2:0]     lane_shift;
    logic [7:0]        nbytes;
    logic [10:0]       nbits;
    logic [NBYTES-1:0] be_base;
    logic [NBYTES-1:0] be;
    logic [XLEN-1:0]   word_old;
    logic [XLEN-1:0]   wshift;
    logic [XLEN-1:0]   word_d;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   val_mask;
    logic [XLEN-1:0]   load_val;
    logic              sign_bit;
    logic [XLEN-1:0]   rdata_d;

    always_comb begin
        cur        = (state_q == S_IDLE) ? req_in : req_q;
        enter_resp = ((state_q == S_IDLE) && req_valid && (WAIT_CYCLES == 0))
                   || ((state_q == S_WAIT) && (cnt_q == 4'd0));
        // Gated by resetn so a store in flight cannot land during reset.
        mem_we     = enter_resp & cur.write & ~cur.err & resetn;

        lane_shift = {cur.lane, 3'b000};
        nbytes     = 8'd1 << cur.size;
        nbits      = {nbytes, 3'b000};
        word_old   = mem_q[cur.idx];

        // Store: enable 2^size lanes starting at the addressed lane.
        be_base    = ~({NBYTES{1'b1}} << nbytes);
        be         = be_base << cur.lane;
        wshift     = cur.wdata << lane_shift;
        word_d     = word_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                word_d[i*8 +: 8] = wshift[i*8 +: 8];
            end
        end

        // Load: right-justify, keep 2^size bytes, then extend. For a full
        // word val_mask is all ones and its top bit is bit XLEN-1, so the
        // extension leaves the value unchanged.
        shifted  = word_old >> lane_shift;
        val_mask = ~({XLEN{1'b1}} << nbits);
        load_val = shifted & val_mask;
        sign_bit = cur.sign & (|(shifted & (val_mask ^ (val_mask >> 1))));
        rdata_d  = '0;
        if (!cur.write && !cur.err) begin
            rdata_d = sign_bit ? (load_val | ~val_mask) : load_val;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ready_q <= enter_resp;
            error_q <= enter_resp & cur.err;
            if (enter_resp) begin
                rdata_q <= rdata_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_q <= req_in;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: the data array has no reset; clearing it would need a port per
    // word and its contents are undefined until written anyway.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cur.idx] <= word_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_error = error_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Four responders: [0] XLEN=64 WAIT=1, [1] XLEN=64 WAIT=0, [2] XLEN=64
// WAIT=3, [3] XLEN=32 WAIT=1. Expected responses are queued when a request
// is driven and popped when the matching mem_ready pulse is observed.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [63:0] addr  [3];
    logic [63:0] wdata [3];
    logic [31:0] addr32;
    logic [31:0] wdata32;
    logic [2:0]  size  [4];
    logic [3:0]  rd, wr, sgn;
    logic [63:0] rdata64 [3];
    logic [31:0] rdata32;
    logic [3:0]  ready, error, busy;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        bit          chk;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    dmem_responder #(.XLEN(64), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .resetn(resetn), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_read_req(rd[0]), .mem_write_req(wr[0]), .mem_size(size[0]), .mem_signed(sgn[0]),
        .mem_rdata(rdata64[0]), .mem_ready(ready[0]), .mem_error(error[0]), .busy(busy[0]));

    dmem_responder #(.XLEN(64), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .resetn(resetn), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_read_req(rd[1]), .mem_write_req(wr[1]), .mem_size(size[1]), .mem_signed(sgn[1]),
        .mem_rdata(rdata64[1]), .mem_ready(ready[1]), .mem_error(error[1]), .busy(busy[1]));

    dmem_responder #(.XLEN(64), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .resetn(resetn), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_read_req(rd[2]), .mem_write_req(wr[2]), .mem_size(size[2]), .mem_signed(sgn[2]),
        .mem_rdata(rdata64[2]), .mem_ready(ready[2]), .mem_error(error[2]), .busy(busy[2]));

    dmem_responder #(.XLEN(32), .WAIT_CYCLES(1)) u_x32 (
        .clk(clk), .resetn(resetn), .mem_addr(addr32), .mem_wdata(wdata32),
        .mem_read_req(rd[3]), .mem_write_req(wr[3]), .mem_size(size[3]), .mem_signed(sgn[3]),
        .mem_rdata(rdata32), .mem_ready(ready[3]), .mem_error(error[3]), .busy(busy[3]));

    function automatic int wait_of(int k);
        case (k)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] rdata_of(int k);
        if (k == 3) return {32'h0, rdata32};
        return rdata64[k];
    endfunction

    task automatic drive(int k, logic r, logic w, logic [2:0] s, logic sg,
                         logic [63:0] a, logic [63:0] d);
        rd[k] = r; wr[k] = w; size[k] = s; sgn[k] = sg;
        if (k == 3) begin
            addr32 = a[31:0]; wdata32 = d[31:0];
        end else begin
            addr[k] = a; wdata[k] = d;
        end
    endtask

    // Counts falling edges until mem_ready is seen, bounded.
    task automatic wait_ready(int k, output int lat, output bit ok);
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (ready[k] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One request: drive, queue the expectation, wait, compare, release.
    task automatic do_txn(int k, logic r, logic w, logic [2:0] s, logic sg,
                          logic [63:0] a, logic [63:0] d,
                          logic [63:0] exp_rdata, logic exp_err, bit chk, string tag);
        int   lat;
        bit   ok;
        exp_t e;
        @(negedge clk);
        drive(k, r, w, s, sg, a, d);
        sb.push_back('{exp_rdata, exp_err, chk, tag});
        wait_ready(k, lat, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s timeout: no mem_ready within 50 cycles", e.tag);
            drive(k, 0, 0, 0, 0, 0, 0);
            return;
        end
        if (lat != 1 + wait_of(k)) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles, want %0d", e.tag, lat, 1 + wait_of(k));
        end
        n_cmp++;
        if (error[k] !== e.err) begin
            n_bad++;
            $display("FAIL %s error: got %b, want %b", e.tag, error[k], e.err);
        end
        if (e.chk) begin
            n_cmp++;
            if (rdata_of(k) !== e.rdata) begin
                n_bad++;
                $display("FAIL %s rdata: got %h, want %h", e.tag, rdata_of(k), e.rdata);
            end
        end
        n_cmp++;
        if (busy[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_in_resp: got %b, want 1", e.tag, busy[k]);
        end
        drive(k, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (ready[k] !== 1'b0 || busy[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s pulse: ready=%b busy=%b after RESP, want 0 0", e.tag, ready[k], busy[k]);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int k = 0; k < 4; k++) drive(k, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({ready[k], error[k], busy[k]} !== 3'b000 || rdata_of(k) !== 64'h0) begin
                n_bad++;
                $display("FAIL reset[%0d]: ready=%b error=%b busy=%b rdata=%h, want all 0",
                         k, ready[k], error[k], busy[k], rdata_of(k));
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_store_load();
        do_txn(0, 0, 1, 3, 0, 64'h10, 64'h1122334455667788, 64'h0, 0, 0, "st_d_0x10");
        do_txn(0, 1, 0, 3, 0, 64'h10, 64'h0, 64'h1122334455667788, 0, 1, "ld_d_0x10");
    endtask

    task automatic test_byte_lanes();
        do_txn(0, 0, 1, 0, 0, 64'h13, 64'h80, 64'h0, 0, 0, "st_b_0x13");
        do_txn(0, 1, 0, 0, 1, 64'h13, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 1, "ld_sb_0x13");
        do_txn(0, 1, 0, 0, 0, 64'h13, 64'h0, 64'h0000000000000080, 0, 1, "ld_ub_0x13");
        do_txn(0, 1, 0, 1, 1, 64'h12, 64'h0, 64'hFFFFFFFFFFFF8066, 0, 1, "ld_sh_0x12");
        do_txn(0, 1, 0, 3, 0, 64'h10, 64'h0, 64'h1122334480667788, 0, 1, "ld_d_merged");
    endtask

    task automatic test_faults();
        do_txn(0, 1, 0, 2, 0, 64'h12, 64'h0, 64'h0, 1, 1, "misaligned_w");
        do_txn(0, 0, 1, 3, 0, 64'd8192, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 0, "out_of_range");
        do_txn(0, 1, 0, 3, 0, 64'h10, 64'h0, 64'h1122334480667788, 0, 1, "ld_after_oor");
        do_txn(0, 1, 1, 3, 0, 64'h10, 64'h5555, 64'h0, 1, 1, "both_reqs");
        do_txn(0, 1, 0, 3, 0, 64'h10, 64'h0, 64'h1122334480667788, 0, 1, "ld_after_both");
    endtask

    task automatic test_back_to_back(int k);
        logic [63:0] v [3];
        int          lat;
        bit          ok;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            v[i] = 64'h0101010101010101 * 64'(i + 1) + 64'(k * 16);
            do_txn(k, 0, 1, 3, 0, 64'h40 + 64'(8 * i), v[i], 64'h0, 0, 0, "b2b_fill");
        end
        @(negedge clk);
        drive(k, 1, 0, 3, 0, 64'h40, 64'h0);
        for (int i = 0; i < 3; i++) sb.push_back('{v[i], 1'b0, 1'b1, "b2b_load"});
        for (int i = 0; i < 3; i++) begin
            wait_ready(k, lat, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL b2b[%0d] timeout: load %0d never completed", k, i);
                break;
            end
            if (lat != ((i == 0) ? 1 + wait_of(k) : wait_of(k) + 2)) begin
                n_bad++;
                $display("FAIL b2b[%0d] spacing of load %0d: got %0d, want %0d", k, i, lat,
                         (i == 0) ? 1 + wait_of(k) : wait_of(k) + 2);
            end
            n_cmp++;
            if (rdata_of(k) !== e.rdata || error[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b[%0d] data of load %0d: got %h err %b, want %h err 0",
                         k, i, rdata_of(k), error[k], e.rdata);
            end
            if (i < 2) drive(k, 1, 0, 3, 0, 64'h40 + 64'(8 * (i + 1)), 64'h0);
            else       drive(k, 0, 0, 0, 0, 0, 0);
        end
        drive(k, 0, 0, 0, 0, 0, 0);
        sb.delete();
    endtask

    task automatic test_reset_mid_store();
        int pulses = 0;
        do_txn(0, 0, 1, 3, 0, 64'h20, 64'h0123456789ABCDEF, 64'h0, 0, 0, "st_d_0x20");
        do_txn(0, 1, 0, 3, 0, 64'h20, 64'h0, 64'h0123456789ABCDEF, 0, 1, "ld_d_0x20");
        @(negedge clk);
        drive(0, 0, 1, 3, 0, 64'h20, 64'hDEADBEEFCAFEF00D);
        @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_store busy_in_wait: got %b, want 1", busy[0]);
        end
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if ({ready[0], error[0], busy[0]} !== 3'b000 || rdata64[0] !== 64'h0) begin
            n_bad++;
            $display("FAIL mid_store in_reset: ready=%b error=%b busy=%b rdata=%h, want all 0",
                     ready[0], error[0], busy[0], rdata64[0]);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready[0] === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL mid_store stray_ready: got %0d pulses, want 0", pulses);
        end
        do_txn(0, 1, 0, 3, 0, 64'h20, 64'h0, 64'h0123456789ABCDEF, 0, 1, "ld_after_reset");
    endtask

    task automatic test_xlen32();
        do_txn(3, 1, 0, 3, 0, 64'h0, 64'h0, 64'h0, 1, 1, "x32_double");
        do_txn(3, 0, 1, 1, 0, 64'h2, 64'h8001, 64'h0, 0, 0, "x32_st_h");
        do_txn(3, 1, 0, 1, 1, 64'h2, 64'h0, 64'h00000000FFFF8001, 0, 1, "x32_ld_sh");
        do_txn(3, 1, 0, 1, 0, 64'h2, 64'h0, 64'h0000000000008001, 0, 1, "x32_ld_uh");
        do_txn(3, 1, 0, 2, 0, 64'h2, 64'h0, 64'h0, 1, 1, "x32_misaligned");
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_faults();
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_mid_store();
        test_xlen32();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
